serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled with start.
REQ-007 The block SHALL have port ci, input, 1 bit: carry-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum/co are newly valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result of a+b+ci, low WIDTH bits.
REQ-011 The block SHALL have port co, output, 1 bit: registered carry-out, bit WIDTH of a+b+ci.

Function
REQ-012 The block SHALL compute with exactly one 1-bit full-adder cell ({co,sum} = a+b+ci), sequenced serially, LSB first, one bit per clock.
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch a, b and ci into internal shift/carry registers, clear the bit counter to 0, and move to RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with all outputs holding.
REQ-016 On each RUN edge, the block SHALL apply operand bit [cnt] and the carry register to the cell, store the cell sum into result bit [cnt], store the cell carry into the carry register, and increment cnt.
REQ-017 On the RUN edge where cnt = WIDTH-1, the block SHALL transfer the full result to sum, the final carry to co, and move to DONE.
REQ-018 In DONE, the block SHALL return to IDLE on the next edge unconditionally.
REQ-019 busy SHALL equal 1 in RUN and 0 in IDLE and DONE; done SHALL equal 1 only in DONE.
REQ-020 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH, and sum/co SHALL be valid from that edge onward.
REQ-021 sum and co SHALL hold their last result until the next completed addition overwrites them; they SHALL NOT change during RUN.
REQ-022 start SHALL be ignored in RUN and DONE; the operands of the operation in flight SHALL not be disturbed.
REQ-023 The minimum issue interval SHALL be WIDTH+2 cycles (start accepted in the first IDLE cycle after DONE).
REQ-024 With WIDTH=1, RUN SHALL last exactly one cycle.
REQ-025 The carry chain SHALL wrap nothing: the carry into bit 0 is ci, and the carry out of bit WIDTH-1 goes only to co.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, busy=0, done=0, sum=0, co=0, cnt=0, and clear the internal registers, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept start normally.
REQ-028 The first rising clk edge after rst_n deasserts SHALL be able to sample start.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, ci=0 -> done after 9 edges, sum=0x96, co=0, busy high for exactly 8 cycles.
REQ-030 WIDTH=8, a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1; then a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1.
REQ-031 WIDTH=8, start held high continuously with changing a/b -> only operands sampled in IDLE are used; done pulses every 10 cycles.
REQ-032 WIDTH=8, rst_n pulsed low at RUN cycle 4 -> no done pulse, sum=0, co=0; next start with a=0x01, b=0x01 -> sum=0x02, co=0.
REQ-033 WIDTH=1, a=1, b=1, ci=1 -> done after 2 edges, sum=1, co=1.
REQ-034 Random regression: at least 1000 random a/b/ci for WIDTH=8 and WIDTH=13 -> {co,sum} equal to a+b+ci in every case.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if -- operand/result bundle for the bit-serial adder.
//   start  : request to begin an addition (master -> slave)
//   a, b   : WIDTH-bit operands, sampled with start (master -> slave)
//   ci     : carry-in, sampled with start (master -> slave)
//   busy   : addition in progress (slave -> master)
//   done   : one-cycle pulse, sum/co newly valid (slave -> master)
//   sum    : registered low WIDTH bits of a+b+ci (slave -> master)
//   co     : registered carry-out, bit WIDTH of a+b+ci (slave -> master)
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             co;

   modport master (
      output start, a, b, ci,
      input  busy, done, sum, co
   );

   modport slave (
      input  start, a, b, ci,
      output busy, done, sum, co
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder built around a single 1-bit full-adder
// cell, processing one operand bit per clock, LSB first.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if slave (start/a/b/ci in, busy/done/sum/co out)
// Timing: start sampled at edge k -> RUN for WIDTH cycles -> DONE (done=1)
// during the cycle after edge k+WIDTH -> IDLE. Issue interval WIDTH+2.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;

   logic             bit_a, bit_b;
   logic             fa_s, fa_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;

      // The one full-adder cell, fed by the bit selected by the counter.
      bit_a = a_q[cnt_q];
      bit_b = b_q[cnt_q];
      fa_s  = bit_a ^ bit_b ^ carry_q;
      fa_c  = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.ci;
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[cnt_q] = fa_s;
            carry_d      = fa_c;
            cnt_d        = cnt_q + 1'b1;
            // Final bit: publish the result including the bit written this
            // cycle, so sum/co only ever change on completion.
            if (cnt_q == LAST) begin
               sum_d   = res_d;
               co_d    = fa_c;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- scoreboard bench for serial_add_ctrl at WIDTH 8, 13, 1.
// Stimulus pushes {co,sum} = a+b+ci and the expected done cycle into a
// per-instance queue; a negedge monitor pops and compares on every done.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8))  i8 ();
   serial_add_ctrl_if #(.WIDTH(13)) i13 ();
   serial_add_ctrl_if #(.WIDTH(1))  i1 ();

   serial_add_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
   serial_add_ctrl #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(i13));
   serial_add_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(i1));

   typedef struct {
      logic [32:0] res;
      int unsigned cyc;
   } exp_t;

   exp_t        q0[$], q1[$], q2[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;
   int unsigned busy_cnt [3];
   logic [32:0] last_res [3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain wide arithmetic, {carry-out, low w bits}.
   function automatic logic [32:0] model(input int unsigned w, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
      logic [63:0] s;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      s    = (64'(a) & mask) + (64'(b) & mask) + 64'(ci);
      return {s[w], 32'(s & mask)};
   endfunction

   function automatic int unsigned width_of(input int idx);
      case (idx)
         0:       return 8;
         1:       return 13;
         default: return 1;
      endcase
   endfunction

   function automatic bit is_idle(input int idx);
      case (idx)
         0:       return !i8.busy && !i8.done;
         1:       return !i13.busy && !i13.done;
         default: return !i1.busy && !i1.done;
      endcase
   endfunction

   task automatic mon(input int idx, input logic busy, input logic done, input logic [32:0] cur);
      exp_t e;
      bit   empty;
      if (!rst_n) begin
         busy_cnt[idx] = 0;
         last_res[idx] = cur;
         return;
      end
      if (busy) begin
         chk($sformatf("hold_w%0d", width_of(idx)), cur, last_res[idx]);
         busy_cnt[idx]++;
      end
      if (done) begin
         chk($sformatf("busy_len_w%0d", width_of(idx)), 33'(busy_cnt[idx]), 33'(width_of(idx)));
         busy_cnt[idx] = 0;
         empty = 1'b0;
         case (idx)
            0:       if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1:       if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
         endcase
         if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done_w%0d: got done=1, required none pending", width_of(idx));
         end else begin
            chk($sformatf("result_w%0d", width_of(idx)), cur, e.res);
            chk($sformatf("latency_w%0d", width_of(idx)), 33'(cyc), 33'(e.cyc));
         end
      end
      last_res[idx] = cur;
   endtask

   always @(negedge clk) begin
      mon(0, i8.busy,  i8.done,  {i8.co,  32'(i8.sum)});
      mon(1, i13.busy, i13.done, {i13.co, 32'(i13.sum)});
      mon(2, i1.busy,  i1.done,  {i1.co,  32'(i1.sum)});
   end

   // Wait (bounded) until the instance is in IDLE; returns at a negedge.
   task automatic wait_idle(input int idx);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (is_idle(idx)) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout_w%0d: got busy, required idle within 100 cycles", width_of(idx));
   endtask

   // Called at a negedge with the instance idle: the next edge samples start.
   task automatic launch(input int idx, input logic [31:0] a, input logic [31:0] b, input logic ci);
      exp_t e;
      case (idx)
         0:       begin i8.a  = a[7:0];  i8.b  = b[7:0];  i8.ci  = ci; i8.start  = 1'b1; end
         1:       begin i13.a = a[12:0]; i13.b = b[12:0]; i13.ci = ci; i13.start = 1'b1; end
         default: begin i1.a  = a[0];    i1.b  = b[0];    i1.ci  = ci; i1.start  = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      e.res = model(width_of(idx), a, b, ci);
      e.cyc = cyc + width_of(idx);
      case (idx)
         0:       begin q0.push_back(e); i8.start  = 1'b0; end
         1:       begin q1.push_back(e); i13.start = 1'b0; end
         default: begin q2.push_back(e); i1.start  = 1'b0; end
      endcase
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #2;
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d pending, required 0/0/0",
               q0.size(), q1.size(), q2.size());
   endtask

   initial begin
      rst_n = 1'b0;
      i8.start  = 1'b0; i8.a  = '0; i8.b  = '0; i8.ci  = 1'b0;
      i13.start = 1'b0; i13.a = '0; i13.b = '0; i13.ci = 1'b0;
      i1.start  = 1'b0; i1.a  = '0; i1.b  = '0; i1.ci  = 1'b0;

      // Reset values, observed before any clock edge.
      #3;
      chk("rst_res_w8",   {i8.co,  32'(i8.sum)},  '0);
      chk("rst_flag_w8",  {31'b0, i8.busy,  i8.done},  '0);
      chk("rst_res_w13",  {i13.co, 32'(i13.sum)}, '0);
      chk("rst_flag_w13", {31'b0, i13.busy, i13.done}, '0);
      chk("rst_res_w1",   {i1.co,  32'(i1.sum)},  '0);
      chk("rst_flag_w1",  {31'b0, i1.busy,  i1.done},  '0);

      // Release and present start at once: the first edge must take it.
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      launch(0, 32'h5A, 32'h3C, 1'b0);
      wait_idle(0); launch(0, 32'hFF, 32'h01, 1'b0);
      wait_idle(0); launch(0, 32'hFF, 32'hFF, 1'b1);
      wait_idle(2); launch(2, 32'h1, 32'h1, 1'b1);
      wait_idle(2); launch(2, 32'h0, 32'h1, 1'b0);
      wait_idle(1); launch(1, 32'h1FFF, 32'h1FFF, 1'b1);
      wait_idle(1); launch(1, 32'h1FFF, 32'h0000, 1'b1);
      drain();

      // start held high with operands changing every cycle: only the
      // values present at each 10-cycle acceptance edge count.
      wait_idle(0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         i8.a     = 8'($urandom);
         i8.b     = 8'($urandom);
         i8.ci    = 1'($urandom_range(0, 1));
         i8.start = 1'b1;
         @(posedge clk);
         #1;
         if (t % 10 == 0) begin
            exp_t e;
            e.res = model(8, 32'(i8.a), 32'(i8.b), i8.ci);
            e.cyc = cyc + 8;
            q0.push_back(e);
         end
      end
      @(negedge clk);
      i8.start = 1'b0;
      drain();

      // Reset in RUN cycle 4 aborts with no done; recovery works at once.
      wait_idle(0); launch(0, 32'hA5, 32'h5A, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      q0.delete();
      #1;
      chk("midrst_res_w8",  {i8.co, 32'(i8.sum)}, '0);
      chk("midrst_flag_w8", {31'b0, i8.busy, i8.done}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      launch(0, 32'h01, 32'h01, 1'b0);
      drain();

      // Random regression on all three widths concurrently.
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               wait_idle(0);
               launch(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int n = 0; n < 1000; n++) begin
               wait_idle(1);
               launch(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int n = 0; n < 100; n++) begin
               wait_idle(2);
               launch(2, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
         end
      join
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
